// File: rtl/encoder_layer_0_output_dense_bias_sink_if.sv
// Bus bundle for the bias sink: beat input handshake, frame control, and the
// ce0-enabled readback port.
interface encoder_layer_0_output_dense_bias_sink_if #(
  parameter int P  = 1,
  parameter int W  = 16,
  parameter int AW = 6
);
  logic [W-1:0]   data_in [P];
  logic           data_in_valid;
  logic           data_in_ready;
  logic           frame_release;
  logic           frame_done;
  logic           frame_full;
  logic [AW-1:0]  beat_count;
  logic [AW-1:0]  address0;
  logic           ce0;
  logic [P*W-1:0] q0;

  modport master (
    output data_in, data_in_valid, frame_release, address0, ce0,
    input  data_in_ready, frame_done, frame_full, beat_count, q0
  );

  modport slave (
    input  data_in, data_in_valid, frame_release, address0, ce0,
    output data_in_ready, frame_done, frame_full, beat_count, q0
  );
endinterface

// File: rtl/encoder_layer_0_output_dense_bias_sink.sv
// Bias frame sink: captures one frame of beats into a RAM, holds it until the
// consumer releases it, and serves a two-stage ce0-gated readback port.
module encoder_layer_0_output_dense_bias_sink #(
  parameter int BIAS_TENSOR_SIZE_DIM_0 = 32,
  parameter int BIAS_PRECISION_0       = 16,
  parameter int BIAS_PARALLELISM_DIM_0 = 1,
  parameter int IN_DEPTH               = BIAS_TENSOR_SIZE_DIM_0 / BIAS_PARALLELISM_DIM_0,
  parameter int ADDR_WIDTH             = $clog2(IN_DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  encoder_layer_0_output_dense_bias_sink_if.slave bus
);
  localparam int W     = BIAS_PRECISION_0;
  localparam int P     = BIAS_PARALLELISM_DIM_0;
  localparam int IDX_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(IN_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(IN_DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  done, done_nxt;
  logic                  accept;
  logic [P*W-1:0]        wr_data, rd_word, rd_s1, rd_s2;
  logic [P*W-1:0]        ram [IN_DEPTH];

  assign accept = bus.data_in_valid && (state == CAPTURE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE:    state_nxt = CAPTURE;
      CAPTURE: if (accept) begin
        if (cnt == LAST_BEAT) begin
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD:    if (bus.frame_release) state_nxt = CAPTURE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  assign bus.data_in_ready = (state == CAPTURE);
  assign bus.frame_full    = (state == HOLD);
  assign bus.frame_done    = done;
  assign bus.beat_count    = cnt;

  // Element j of a beat occupies bits [W*j +: W] of the RAM word.
  for (genvar j = 0; j < P; j++) begin : g_lane
    assign wr_data[W*j +: W] = bus.data_in[j];
  end

  // RAM has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (accept) ram[cnt[IDX_W-1:0]] <= wr_data;
  end

  // Out-of-range addresses read as zero; same-edge write is seen next read.
  assign rd_word = (bus.address0 < DEPTH_A) ? ram[bus.address0[IDX_W-1:0]] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_s1 <= '0;
      rd_s2 <= '0;
    end else if (bus.ce0) begin
      rd_s1 <= rd_word;
      rd_s2 <= rd_s1;
    end
  end

  assign bus.q0 = rd_s2;
endmodule

// File: tb/tb_encoder_layer_0_output_dense_bias_sink.sv
// Directed/random bench for the bias sink against a frame-level reference model.
module tb_encoder_layer_0_output_dense_bias_sink;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  encoder_layer_0_output_dense_bias_sink_if #(.P(1), .W(16), .AW(6)) bus ();

  encoder_layer_0_output_dense_bias_sink dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = waiting to start, 1 = filling, 2 = frame held.
  int          mode = 0;
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic [15:0] mem [DEPTH];
  logic [15:0] pipe1 = '0, pipe2 = '0;
  int          done_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".ready"}, 64'(bus.data_in_ready), 64'(mode == 1));
    chk({tag, ".full"},  64'(bus.frame_full),    64'(mode == 2));
    chk({tag, ".done"},  64'(bus.frame_done),    64'(m_done));
    chk({tag, ".cnt"},   64'(bus.beat_count),    64'(m_cnt));
    chk({tag, ".q0"},    64'(bus.q0),            64'(pipe2));
  endtask

  // One clock: advance the model from the inputs currently applied, then check.
  task automatic cycle(input string tag);
    logic [15:0] rd;
    rd = (int'(bus.address0) < DEPTH) ? mem[bus.address0] : 16'h0;
    if (bus.ce0) begin
      pipe2 = pipe1;
      pipe1 = rd;
    end
    m_done = 1'b0;
    if (mode == 0) mode = 1;
    else if (mode == 1 && bus.data_in_valid) begin
      mem[m_cnt] = bus.data_in[0];
      if (m_cnt == DEPTH - 1) begin
        m_cnt = 0;
        m_done = 1'b1;
        mode = 2;
      end else m_cnt++;
    end else if (mode == 2 && bus.frame_release) mode = 1;
    @(posedge clk);
    #1;
    if (bus.frame_done) done_seen++;
    chk_outputs(tag);
  endtask

  task automatic model_reset();
    mode = 0; m_cnt = 0; m_done = 1'b0; pipe1 = '0; pipe2 = '0;
  endtask

  initial begin
    bus.data_in[0]    = '0;
    bus.data_in_valid = 1'b0;
    bus.frame_release = 1'b0;
    bus.address0      = '0;
    bus.ce0           = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset");

    // Release with valid held high: first edge only starts capture
    bus.data_in_valid = 1'b1;
    bus.data_in[0]    = 16'h0001;
    rst = 1'b1;
    #1;
    chk("rel.ready_before", 64'(bus.data_in_ready), 64'd0);
    cycle("start");

    // Full frame of 1..32, continuous
    done_seen = 0;
    for (int i = 1; i <= DEPTH; i++) begin
      bus.data_in[0] = 16'(i);
      cycle("frame1");
    end
    chk("frame1.done_count", 64'(done_seen), 64'd1);
    chk("frame1.entry0", 64'(mem[0]), 64'h1);

    // Readback of entry 5 while held
    bus.ce0 = 1'b1;
    bus.address0 = 6'd5;
    cycle("rd5a");
    cycle("rd5b");
    chk("rd5.q0", 64'(bus.q0), 64'h0006);

    // Hold 3 cycles with valid high: nothing is written
    bus.ce0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.data_in[0] = 16'($urandom);
      cycle("hold");
    end
    bus.frame_release = 1'b1;
    cycle("release");
    bus.frame_release = 1'b0;

    // Random gaps, random readback across all addresses incl. out of range
    done_seen = 0;
    for (int i = 0; i < 400 && mode == 1; i++) begin
      bus.data_in_valid = 1'($urandom_range(0, 1));
      bus.data_in[0]    = 16'($urandom);
      bus.ce0           = 1'($urandom_range(0, 1));
      bus.address0      = 6'($urandom_range(0, 40));
      bus.frame_release = 1'($urandom_range(0, 1));
      cycle("frame2");
    end
    chk("frame2.held", 64'(bus.frame_full), 64'd1);
    chk("frame2.done_count", 64'(done_seen), 64'd1);

    // Drain readback of every entry of the held frame
    bus.frame_release = 1'b0;
    bus.ce0 = 1'b1;
    for (int a = 0; a < DEPTH + 2; a++) begin
      bus.address0 = 6'(a);
      cycle("dump");
    end

    // Start a frame, reset after 10 beats
    bus.frame_release = 1'b1;
    cycle("release2");
    bus.frame_release = 1'b0;
    bus.data_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.data_in[0] = 16'($urandom);
      cycle("partial");
    end
    rst = 1'b0;
    #1;
    model_reset();
    chk_outputs("midreset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle("restart");
    done_seen = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.data_in[0] = 16'($urandom);
      cycle("frame3");
    end
    chk("frame3.done_count", 64'(done_seen), 64'd1);
    chk("frame3.held", 64'(bus.frame_full), 64'd1);

    // Out-of-range read, then drop ce0 and confirm q0 holds
    bus.data_in_valid = 1'b0;
    bus.address0 = 6'd3;
    cycle("rd3a");
    cycle("rd3b");
    bus.address0 = 6'd40;
    cycle("rd40a");
    bus.ce0 = 1'b0;
    cycle("rd40_hold1");
    chk("hold.q0_is_entry3", 64'(bus.q0), 64'(mem[3]));
    bus.ce0 = 1'b1;
    cycle("rd40b");
    chk("rd40.zero", 64'(bus.q0), 64'd0);
    bus.ce0 = 1'b0;
    bus.address0 = 6'd7;
    repeat (3) cycle("ce0_off");
    chk("ce0_off.q0", 64'(bus.q0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/encoder_layer_0_output_dense_bias_sink.md
ENCODER_LAYER_0_OUTPUT_DENSE_BIAS_SINK -- requirements
Module: encoder_layer_0_output_dense_bias_sink

Interface
REQ-001 Parameter BIAS_TENSOR_SIZE_DIM_0, default 32: total elements per frame.
REQ-002 Parameter BIAS_PRECISION_0, default 16: element width, bits.
REQ-003 Parameter BIAS_PARALLELISM_DIM_0, default 1: elements per beat (P).
REQ-004 Parameter IN_DEPTH, default BIAS_TENSOR_SIZE_DIM_0/BIAS_PARALLELISM_DIM_0: beats per frame.
REQ-005 Parameter ADDR_WIDTH, default $clog2(IN_DEPTH)+1: pointer and address width.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-008 data_in  input  P x BIAS_PRECISION_0  unpacked array of beat elements.
REQ-009 data_in_valid  input  1  beat present.
REQ-010 data_in_ready  output  1  sink accepts beat.
REQ-011 frame_release  input  1  consumer frees a held frame.
REQ-012 frame_done  output  1  one-cycle pulse, last beat of frame accepted.
REQ-013 frame_full  output  1  level, complete frame held.
REQ-014 beat_count  output  ADDR_WIDTH  beats accepted in current frame.
REQ-015 address0  input  ADDR_WIDTH  readback beat address.
REQ-016 ce0  input  1  readback pipeline enable.
REQ-017 q0  output  P x BIAS_PRECISION_0 bits, packed  readback data, element j at bits [W*j+W-1 : W*j], W = BIAS_PRECISION_0.

Function
REQ-018 FSM states: IDLE, CAPTURE, HOLD; registered; reset state IDLE.
REQ-019 IDLE -> CAPTURE unconditionally on first rising clk edge after rst deasserts.
REQ-020 data_in_ready SHALL be registered-state decoded: 1 only in CAPTURE, 0 in IDLE and HOLD.
REQ-021 Beat accepted iff data_in_valid && data_in_ready on a rising edge; the beat is written to RAM entry beat_count, all P elements packed per REQ-017.
REQ-022 On accept with beat_count < IN_DEPTH-1: beat_count increments by 1, state stays CAPTURE.
REQ-023 On accept with beat_count == IN_DEPTH-1: beat_count wraps to 0, frame_done = 1 for the next cycle only, state -> HOLD.
REQ-024 frame_full = 1 exactly while in HOLD.
REQ-025 HOLD -> CAPTURE on a rising edge with frame_release = 1; data_in_ready = 1 the following cycle.
REQ-026 frame_release SHALL be ignored in IDLE and CAPTURE, including in the same cycle as the last-beat accept.
REQ-027 data_in_valid without ready SHALL NOT change beat_count or RAM.
REQ-028 Readback: a two-stage register pipeline, both stages enabled by ce0; q0 equals RAM[address0] sampled two enabled edges earlier; with ce0 = 0, q0 holds.
REQ-029 Readback is legal in any state; same-cycle read and write of one entry returns the old contents (read-before-write).
REQ-030 address0 >= IN_DEPTH SHALL return all-zero data through the pipeline.
REQ-031 RAM contents are not cleared by reset; unwritten entries are undefined.

Reset
REQ-032 While rst = 0: state IDLE, beat_count = 0, data_in_ready = 0, frame_done = 0, frame_full = 0, both readback stages and q0 = 0; all outputs take these values asynchronously.
REQ-033 Reset asserted mid-frame discards the partial frame; after release capture restarts at entry 0.
REQ-034 Reset asserted in HOLD clears frame_full; the held frame is no longer guaranteed valid.

Verification
REQ-035 Reset release, valid held 1 -> ready 0 for the first post-reset edge, 1 from the next; first beat lands at entry 0.
REQ-036 32 continuous beats, values 0x0001..0x0020, P = 1 -> frame_done pulses once after beat 32, frame_full = 1, ready = 0, beat_count = 0; ce0 = 1, address0 = 5 -> q0 = 0x0006 two edges later.
REQ-037 Random valid gaps (~50%) over one frame -> beat_count increments only on accept; RAM matches the accepted sequence.
REQ-038 Hold 3 cycles with valid = 1, then pulse frame_release -> no writes during HOLD; ready = 1 the cycle after release; the next frame overwrites entry 0 first.
REQ-039 Reset asserted after 10 beats -> outputs zero immediately; after release a full 32-beat frame completes with frame_done exactly once.
REQ-040 address0 = 40, ce0 = 1 -> q0 = 0; ce0 dropped mid-read -> q0 holds its prior value.
